// File: rtl/bcd_scan_ctrl_if.sv
// bcd_scan_ctrl_if: count controls in, scanned display and live count out.
// master drives inc/clr/hold; slave is the scan controller.
interface bcd_scan_ctrl_if;
    logic        inc;
    logic        clr;
    logic        hold;
    logic [3:0]  C;
    logic [3:0]  AN;
    logic        ovf;
    logic [15:0] val;

    modport master (
        output inc,
        output clr,
        output hold,
        input  C,
        input  AN,
        input  ovf,
        input  val
    );

    modport slave (
        input  inc,
        input  clr,
        input  hold,
        output C,
        output AN,
        output ovf,
        output val
    );
endinterface

// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: 4-digit cascaded BCD counter with a multiplexed
// 7-segment scan, dead-time gaps and leading-zero blanking.
module bcd_scan_ctrl #(
    parameter int DIV       = 1000,
    parameter int BLANK_CYC = 4
) (
    input logic            P,
    input logic            R,
    bcd_scan_ctrl_if.slave bus
);
    localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] ON_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic {
        S_ON,
        S_BLANK
    } state_t;

    state_t         st_q;
    state_t         st_n;
    logic [1:0]     k_q;
    logic [1:0]     k_n;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_n;
    logic [15:0]    snap_q;
    logic [15:0]    snap_n;
    logic [15:0]    val_q;
    logic [15:0]    val_n;
    logic           ovf_q;
    logic           ovf_n;
    logic [3:0]     an_q;
    logic [3:0]     an_n;
    logic [3:0]     c_q;
    logic [3:0]     c_n;
    logic           carry;

    function automatic logic [3:0] dig_sel(
        input logic [15:0] s,
        input logic [1:0]  d
    );
        return s[{d, 2'b00} +: 4];
    endfunction

    // digit d is dark when it and everything above it is zero
    function automatic logic lz_blank(
        input logic [15:0] s,
        input logic [1:0]  d
    );
        logic [15:0] hi;
        hi = s >> {d, 2'b00};
        return (d != 2'd0) && (hi == 16'd0);
    endfunction

    always_comb begin
        val_n = val_q;
        ovf_n = 1'b0;
        carry = bus.inc;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (val_q[4*i +: 4] == 4'd9) begin
                    val_n[4*i +: 4] = 4'd0;
                end else begin
                    val_n[4*i +: 4] = val_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (bus.clr) begin
            val_n = 16'h0000;
        end else begin
            ovf_n = carry;
        end
    end

    always_comb begin
        st_n   = st_q;
        k_n    = k_q;
        cnt_n  = cnt_q + 1'b1;
        snap_n = snap_q;
        case (st_q)
            S_ON: begin
                if (cnt_q == ON_LAST) begin
                    st_n  = S_BLANK;
                    cnt_n = '0;
                end
            end
            S_BLANK: begin
                if (cnt_q == BL_LAST) begin
                    st_n  = S_ON;
                    cnt_n = '0;
                    k_n   = k_q + 2'd1;
                    if (k_q == 2'd3 && !bus.hold) begin
                        snap_n = val_q;
                    end
                end
            end
            default: begin
                st_n  = S_ON;
                cnt_n = '0;
            end
        endcase
        an_n = 4'b1111;
        c_n  = 4'd0;
        if (st_n == S_ON && !lz_blank(snap_n, k_n)) begin
            an_n = ~(4'b0001 << k_n);
            c_n  = dig_sel(snap_n, k_n);
        end
    end

    always_ff @(posedge P or negedge R) begin
        if (!R) begin
            st_q   <= S_ON;
            k_q    <= 2'd0;
            cnt_q  <= '0;
            snap_q <= 16'h0000;
            an_q   <= 4'b1110;
            c_q    <= 4'd0;
        end else begin
            st_q   <= st_n;
            k_q    <= k_n;
            cnt_q  <= cnt_n;
            snap_q <= snap_n;
            an_q   <= an_n;
            c_q    <= c_n;
        end
    end

    always_ff @(posedge P or negedge R) begin
        if (!R) begin
            val_q <= 16'h0000;
            ovf_q <= 1'b0;
        end else begin
            val_q <= val_n;
            ovf_q <= ovf_n;
        end
    end

    assign bus.C   = c_q;
    assign bus.AN  = an_q;
    assign bus.ovf = ovf_q;
    assign bus.val = val_q;
endmodule
